// File: rtl/psw_reveal_timer.sv
// Password reveal timer: latches a password on start, shows it on the LED bank and
// counts down SECONDS on two scanned 7-segment digits, then raises a sticky done flag.
module psw_reveal_timer #(
    parameter int PSW_W         = 7,
    parameter int SECONDS       = 5,
    parameter int TICKS_PER_SEC = 220,
    parameter int SCAN_DIV      = 4,
    parameter int BLINK         = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PSW_W-1:0] psw,
    output logic [PSW_W-1:0] LD,
    output logic [7:0]       seg,
    output logic [7:0]       cat,
    output logic             busy,
    output logic             endOfShow
);

    localparam int TW = $clog2(TICKS_PER_SEC);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_SEC / 2);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    TENS_INIT = 4'(SECONDS / 10);
    localparam logic [3:0]    UNITS_INIT = 4'(SECONDS % 10);

    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [PSW_W-1:0] psw_q;
    logic [TW-1:0]    tick;
    logic [SW-1:0]    scan_cnt;
    logic             slot;
    logic [3:0]       tens, units;
    logic [PSW_W-1:0] ld_nxt;
    logic             load, tick_last, last_sec;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: glyph = 8'h3F;
            4'd1: glyph = 8'h06;
            4'd2: glyph = 8'h5B;
            4'd3: glyph = 8'h4F;
            4'd4: glyph = 8'h66;
            4'd5: glyph = 8'h6D;
            4'd6: glyph = 8'h7D;
            4'd7: glyph = 8'h07;
            4'd8: glyph = 8'h7F;
            4'd9: glyph = 8'h6F;
            default: glyph = 8'h00;
        endcase
    endfunction

    // Abort has priority over start in every state.
    assign load      = start & ~abort;
    assign tick_last = (tick == TICK_LAST);
    assign last_sec  = (tens == 4'd0) && (units == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = SHOW;
            SHOW: begin
                if (abort)                      state_nxt = IDLE;
                else if (load)                  state_nxt = SHOW;
                else if (tick_last && last_sec) state_nxt = DONE;
            end
            DONE: begin
                if (abort)     state_nxt = IDLE;
                else if (load) state_nxt = SHOW;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psw_q    <= '0;
            tick     <= '0;
            scan_cnt <= '0;
            slot     <= 1'b0;
            tens     <= 4'd0;
            units    <= 4'd0;
        end else if (load) begin
            psw_q    <= psw;
            tick     <= '0;
            scan_cnt <= '0;
            slot     <= 1'b0;
            tens     <= TENS_INIT;
            units    <= UNITS_INIT;
        end else if (state == SHOW) begin
            if (tick_last) begin
                tick <= '0;
                // BCD borrow; remaining time is always >= 1 while in SHOW.
                if (units == 4'd0) begin
                    units <= 4'd9;
                    tens  <= tens - 4'd1;
                end else begin
                    units <= units - 4'd1;
                end
            end else begin
                tick <= tick + TW'(1);
            end
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                slot     <= ~slot;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

    always_comb begin
        ld_nxt    = '0;
        seg       = 8'h00;
        cat       = 8'hFF;
        busy      = (state == SHOW);
        endOfShow = (state == DONE);
        if (state == SHOW) begin
            if (BLINK == 0 || tick < TICK_HALF) ld_nxt = psw_q;
            if (!slot) begin
                cat = 8'hFE;
                seg = glyph(units);
            end else if (tens != 4'd0) begin
                cat = 8'hFD;
                seg = glyph(tens);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) LD <= '0;
        else        LD <= ld_nxt;
    end

endmodule

// File: tb/tb_psw_reveal_timer.sv
// Directed bench for psw_reveal_timer: three instances cover default, two-digit and blink setups.
module tb_psw_reveal_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int j = 0;

    // default instance (SECONDS=5, TICKS_PER_SEC=220)
    logic       start_d = 0, abort_d = 0;
    logic [6:0] psw_d = 0, ld_d;
    logic [7:0] seg_d, cat_d;
    logic       busy_d, eos_d;
    // two-digit instance (SECONDS=12, TICKS_PER_SEC=8)
    logic       start_t = 0, abort_t = 0;
    logic [6:0] psw_t = 0, ld_t;
    logic [7:0] seg_t, cat_t;
    logic       busy_t, eos_t;
    // blink instance (SECONDS=5, TICKS_PER_SEC=8, BLINK=1)
    logic       start_b = 0, abort_b = 0;
    logic [6:0] psw_b = 0, ld_b;
    logic [7:0] seg_b, cat_b;
    logic       busy_b, eos_b;

    psw_reveal_timer u_def (
        .clk(clk), .rst_n(rst_n), .start(start_d), .abort(abort_d), .psw(psw_d),
        .LD(ld_d), .seg(seg_d), .cat(cat_d), .busy(busy_d), .endOfShow(eos_d));

    psw_reveal_timer #(.SECONDS(12), .TICKS_PER_SEC(8)) u_two (
        .clk(clk), .rst_n(rst_n), .start(start_t), .abort(abort_t), .psw(psw_t),
        .LD(ld_t), .seg(seg_t), .cat(cat_t), .busy(busy_t), .endOfShow(eos_t));

    psw_reveal_timer #(.TICKS_PER_SEC(8), .BLINK(1)) u_blink (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .psw(psw_b),
        .LD(ld_b), .seg(seg_b), .cat(cat_b), .busy(busy_b), .endOfShow(eos_b));

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0: glyph = 8'h3F; 1: glyph = 8'h06; 2: glyph = 8'h5B; 3: glyph = 8'h4F;
            4: glyph = 8'h66; 5: glyph = 8'h6D; 6: glyph = 8'h7D; 7: glyph = 8'h07;
            8: glyph = 8'h7F; 9: glyph = 8'h6F; default: glyph = 8'h00;
        endcase
    endfunction

    // j counts falling edges since the edge that accepted the last start
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        j += n;
    endtask

    task automatic pulse_start_d(input logic [6:0] p);
        psw_d = p; start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0; j = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ld_d !== 7'h00) begin n_fail++; $display("FAIL rst_ld: got %h want 00", ld_d); end
        n_checks++; if (seg_d !== 8'h00) begin n_fail++; $display("FAIL rst_seg: got %h want 00", seg_d); end
        n_checks++; if (cat_d !== 8'hFF) begin n_fail++; $display("FAIL rst_cat: got %h want FF", cat_d); end
        n_checks++; if (busy_d !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_d); end
        n_checks++; if (eos_d !== 1'b0) begin n_fail++; $display("FAIL rst_eos: got %b want 0", eos_d); end
        n_checks++; if (cat_t !== 8'hFF) begin n_fail++; $display("FAIL rst_cat_two: got %h want FF", cat_t); end
        n_checks++; if (ld_b !== 7'h00) begin n_fail++; $display("FAIL rst_ld_blink: got %h want 00", ld_b); end
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        n_checks++; if (busy_d !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy_d); end
    endtask

    task automatic test_single_show;
        int rem, sl;
        logic [7:0] e_cat, e_seg;
        pulse_start_d(7'h55);
        n_checks++; if (busy_d !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", busy_d); end
        n_checks++; if (ld_d !== 7'h00) begin n_fail++; $display("FAIL t1_ld_latency: got %h want 00", ld_d); end
        step(1);
        n_checks++; if (ld_d !== 7'h55) begin n_fail++; $display("FAIL t1_ld_on: got %h want 55", ld_d); end
        for (int k = 0; k < 5; k++) begin
            for (int o = 0; o < 2; o++) begin
                step(k * 220 + 2 + o * 4 - j);
                rem = 5 - k;
                sl = (j / 4) % 2;
                e_cat = (sl == 0) ? 8'hFE : 8'hFF;
                e_seg = (sl == 0) ? glyph(rem) : 8'h00;
                n_checks++; if (cat_d !== e_cat) begin n_fail++; $display("FAIL t1_cat j=%0d: got %h want %h", j, cat_d, e_cat); end
                n_checks++; if (seg_d !== e_seg) begin n_fail++; $display("FAIL t1_seg j=%0d: got %h want %h", j, seg_d, e_seg); end
            end
        end
        step(1099 - j);
        n_checks++; if (eos_d !== 1'b0) begin n_fail++; $display("FAIL t1_eos_early: got %b want 0", eos_d); end
        n_checks++; if (busy_d !== 1'b1) begin n_fail++; $display("FAIL t1_busy_late: got %b want 1", busy_d); end
        step(1);
        n_checks++; if (eos_d !== 1'b1) begin n_fail++; $display("FAIL t1_eos: got %b want 1", eos_d); end
        n_checks++; if (busy_d !== 1'b0) begin n_fail++; $display("FAIL t1_busy_done: got %b want 0", busy_d); end
        n_checks++; if (cat_d !== 8'hFF) begin n_fail++; $display("FAIL t1_cat_done: got %h want FF", cat_d); end
        n_checks++; if (seg_d !== 8'h00) begin n_fail++; $display("FAIL t1_seg_done: got %h want 00", seg_d); end
        n_checks++; if (ld_d !== 7'h55) begin n_fail++; $display("FAIL t1_ld_lag: got %h want 55", ld_d); end
        step(1);
        n_checks++; if (ld_d !== 7'h00) begin n_fail++; $display("FAIL t1_ld_off: got %h want 00", ld_d); end
        n_checks++; if (eos_d !== 1'b1) begin n_fail++; $display("FAIL t1_eos_sticky: got %b want 1", eos_d); end
    endtask

    task automatic test_two_digit;
        int pts[8] = '{1, 5, 10, 17, 21, 25, 29, 33};
        logic [7:0] e_cat[8] = '{8'hFE, 8'hFD, 8'hFE, 8'hFE, 8'hFD, 8'hFE, 8'hFF, 8'hFE};
        logic [7:0] e_seg[8] = '{8'h5B, 8'h06, 8'h06, 8'h3F, 8'h06, 8'h6F, 8'h00, 8'h7F};
        psw_t = 7'h2A; start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0; j = 0;
        for (int i = 0; i < 8; i++) begin
            step(pts[i] - j);
            n_checks++; if (cat_t !== e_cat[i]) begin n_fail++; $display("FAIL t2_cat j=%0d: got %h want %h", j, cat_t, e_cat[i]); end
            n_checks++; if (seg_t !== e_seg[i]) begin n_fail++; $display("FAIL t2_seg j=%0d: got %h want %h", j, seg_t, e_seg[i]); end
        end
        step(95 - j);
        n_checks++; if (eos_t !== 1'b0) begin n_fail++; $display("FAIL t2_eos_early: got %b want 0", eos_t); end
        step(1);
        n_checks++; if (eos_t !== 1'b1) begin n_fail++; $display("FAIL t2_eos: got %b want 1", eos_t); end
        n_checks++; if (busy_t !== 1'b0) begin n_fail++; $display("FAIL t2_busy: got %b want 0", busy_t); end
    endtask

    task automatic test_abort;
        pulse_start_d(7'h55);
        step(550 - j);
        n_checks++; if (busy_d !== 1'b1) begin n_fail++; $display("FAIL t3_busy_pre: got %b want 1", busy_d); end
        abort_d = 1'b1;
        @(negedge clk);
        abort_d = 1'b0;
        n_checks++; if (busy_d !== 1'b0) begin n_fail++; $display("FAIL t3_busy: got %b want 0", busy_d); end
        n_checks++; if (eos_d !== 1'b0) begin n_fail++; $display("FAIL t3_eos: got %b want 0", eos_d); end
        n_checks++; if (seg_d !== 8'h00) begin n_fail++; $display("FAIL t3_seg: got %h want 00", seg_d); end
        n_checks++; if (cat_d !== 8'hFF) begin n_fail++; $display("FAIL t3_cat: got %h want FF", cat_d); end
        @(negedge clk);
        n_checks++; if (ld_d !== 7'h00) begin n_fail++; $display("FAIL t3_ld: got %h want 00", ld_d); end
        start_d = 1'b1; abort_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0; abort_d = 1'b0;
        n_checks++; if (busy_d !== 1'b0) begin n_fail++; $display("FAIL t3_both_busy: got %b want 0", busy_d); end
        n_checks++; if (cat_d !== 8'hFF) begin n_fail++; $display("FAIL t3_both_cat: got %h want FF", cat_d); end
        repeat (2) @(negedge clk);
        n_checks++; if (ld_d !== 7'h00) begin n_fail++; $display("FAIL t3_both_ld: got %h want 00", ld_d); end
        n_checks++; if (eos_d !== 1'b0) begin n_fail++; $display("FAIL t3_both_eos: got %b want 0", eos_d); end
    endtask

    task automatic test_restart;
        pulse_start_d(7'h0F);
        step(100);
        psw_d = 7'h11;
        step(200 - j);
        n_checks++; if (ld_d !== 7'h0F) begin n_fail++; $display("FAIL t4_ld_hold: got %h want 0F", ld_d); end
        step(660 - j);
        pulse_start_d(7'h70);
        step(1);
        n_checks++; if (ld_d !== 7'h70) begin n_fail++; $display("FAIL t4_ld_new: got %h want 70", ld_d); end
        step(1);
        n_checks++; if (cat_d !== 8'hFE) begin n_fail++; $display("FAIL t4_cat: got %h want FE", cat_d); end
        n_checks++; if (seg_d !== 8'h6D) begin n_fail++; $display("FAIL t4_seg: got %h want 6D", seg_d); end
        step(1099 - j);
        n_checks++; if (eos_d !== 1'b0) begin n_fail++; $display("FAIL t4_eos_early: got %b want 0", eos_d); end
        step(1);
        n_checks++; if (eos_d !== 1'b1) begin n_fail++; $display("FAIL t4_eos: got %b want 1", eos_d); end
        step(1);
        pulse_start_d(7'h2A);
        n_checks++; if (eos_d !== 1'b0) begin n_fail++; $display("FAIL t4_eos_clear: got %b want 0", eos_d); end
        n_checks++; if (busy_d !== 1'b1) begin n_fail++; $display("FAIL t4_busy_again: got %b want 1", busy_d); end
        step(1);
        n_checks++; if (ld_d !== 7'h2A) begin n_fail++; $display("FAIL t4_ld_again: got %h want 2A", ld_d); end
        abort_d = 1'b1;
        @(negedge clk);
        abort_d = 1'b0;
        n_checks++; if (busy_d !== 1'b0) begin n_fail++; $display("FAIL t4_abort_done: got %b want 0", busy_d); end
    endtask

    task automatic test_blink;
        logic [6:0] e_ld;
        psw_b = 7'h7F; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; j = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            e_ld = (((k - 1) % 8) < 4) ? 7'h7F : 7'h00;
            n_checks++; if (ld_b !== e_ld) begin n_fail++; $display("FAIL t5_ld j=%0d: got %h want %h", j, ld_b, e_ld); end
            if (k == 39) begin
                n_checks++; if (eos_b !== 1'b0) begin n_fail++; $display("FAIL t5_eos_early: got %b want 0", eos_b); end
            end
        end
        n_checks++; if (eos_b !== 1'b1) begin n_fail++; $display("FAIL t5_eos: got %b want 1", eos_b); end
        step(1);
        n_checks++; if (ld_b !== 7'h00) begin n_fail++; $display("FAIL t5_ld_done: got %h want 00", ld_b); end
    endtask

    task automatic test_async_reset;
        pulse_start_d(7'h55);
        step(440 - j);
        n_checks++; if (ld_d !== 7'h55) begin n_fail++; $display("FAIL t6_ld_pre: got %h want 55", ld_d); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ld_d !== 7'h00) begin n_fail++; $display("FAIL t6_ld: got %h want 00", ld_d); end
        n_checks++; if (seg_d !== 8'h00) begin n_fail++; $display("FAIL t6_seg: got %h want 00", seg_d); end
        n_checks++; if (cat_d !== 8'hFF) begin n_fail++; $display("FAIL t6_cat: got %h want FF", cat_d); end
        n_checks++; if (busy_d !== 1'b0) begin n_fail++; $display("FAIL t6_busy: got %b want 0", busy_d); end
        n_checks++; if (eos_d !== 1'b0) begin n_fail++; $display("FAIL t6_eos: got %b want 0", eos_d); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (busy_d !== 1'b0) begin n_fail++; $display("FAIL t6_post_busy: got %b want 0", busy_d); end
        n_checks++; if (ld_d !== 7'h00) begin n_fail++; $display("FAIL t6_post_ld: got %h want 00", ld_d); end
        n_checks++; if (cat_d !== 8'hFF) begin n_fail++; $display("FAIL t6_post_cat: got %h want FF", cat_d); end
    endtask

    initial begin
        test_reset();
        test_single_show();
        test_two_digit();
        test_abort();
        test_restart();
        test_blink();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete within 1000000 time units");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/psw_reveal_timer.md
Name: psw_reveal_timer

Overview:
- Parametrised successor to the single-digit password reveal block.
- On a start pulse, it latches the password, shows it on the LED bank, and counts down a configurable number of seconds on two scanned 7-segment digits.
- When the countdown ends, it blanks the LEDs and the display and raises a sticky end-of-show flag.
- Sits between the game-control FSM (start/abort/end handshake) and the board LED/7-seg pins. Adds abort, restart, optional LED blink and a two-digit countdown.

Parameters:
- PSW_W, 7, password/LED width (1..16).
- SECONDS, 5, countdown length in seconds (1..99).
- TICKS_PER_SEC, 220, clk cycles per displayed second (>=4, even).
- SCAN_DIV, 4, clk cycles per digit-scan slot (>=1).
- BLINK, 0, 1 = LEDs lit only in the first half of each second; 0 = steady.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request to begin a show
- abort  in  1  one-cycle request to cancel a show
- psw  in  PSW_W  password to reveal, sampled on start
- LD  out  PSW_W  LED bank, active-high
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-high
- cat  out  8  digit cathodes, active-low; only cat[0] (units) and cat[1] (tens) are ever driven low
- busy  out  1  high while in SHOW
- endOfShow  out  1  sticky completion flag

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE. LD=0, seg=0, cat=8'hFF, busy=0, endOfShow=0.
  - All counters and the password latch are cleared.
  - Takes effect immediately, including mid-show.
- States and transitions:
  - IDLE -> SHOW on start.
  - SHOW -> DONE when remaining time reaches 0.
  - SHOW -> IDLE on abort.
  - DONE -> SHOW on start.
  - DONE -> IDLE on abort.
- On the edge where start is accepted (from IDLE or DONE):
  - psw_q<=psw, remain<=SECONDS, tick counter<=0, endOfShow<=0, busy<=1.
- start while already in SHOW:
  - Restart: re-latch psw, remain<=SECONDS, tick counter<=0.
- start and abort in the same cycle: abort wins.
- SHOW:
  - tick counter counts 0..TICKS_PER_SEC-1. At terminal count it wraps to 0 and remain decrements.
  - When remain goes 1->0, the next state is DONE. endOfShow goes 1 and busy goes 0 in the same cycle that DONE is entered.
  - Visible time from the start edge to endOfShow high is exactly SECONDS*TICKS_PER_SEC cycles.
- LD (registered):
  - SHOW with BLINK=0: LD=psw_q.
  - SHOW with BLINK=1: LD=psw_q while tick counter < TICKS_PER_SEC/2, else 0.
  - IDLE and DONE: LD=0.
  - LD updates one cycle after the state/counter change, i.e. 1-cycle output latency.
- Display:
  - remain is held as two BCD digits (tens, units). Decrement borrows: units 0 -> 9 with tens-1.
  - The scan slot toggles every SCAN_DIV cycles while SHOW. Slot 0 drives cat=8'hFE with the units glyph; slot 1 drives cat=8'hFD with the tens glyph.
  - If tens=0, the tens slot keeps cat=8'hFF and seg=0 (leading-zero blanking).
  - Glyphs 0-9 use standard encoding, dp=0: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - IDLE and DONE: seg=0, cat=8'hFF.
  - A restart resets the scan slot to 0.
- endOfShow:
  - Held high in DONE until the next accepted start, an abort, or reset.
  - Abort from SHOW leaves endOfShow at 0.
- psw changes during SHOW are ignored; only the latched value is displayed.
- Tick counter width is $clog2(TICKS_PER_SEC). remain/BCD never underflows; there is no decrement in DONE.

Test Plan:
1. Reset and single show. Defaults, rst_n low then high, psw=7'h55, start pulse at cycle 10 -> LD=7'h55 from cycle 12. Units digit shows 5,4,3,2,1 at each 220-cycle boundary. endOfShow=1 and busy=0 at cycle 11+1100. LD=0, cat=FF after.
2. Two-digit countdown. SECONDS=12, TICKS_PER_SEC=8 -> cat alternates FE/FD every 4 cycles with digits "1","2". After 3 seconds it shows "0","9": tens blanked (cat stays FF in slot 1), units seg=6F.
3. Abort mid-show. Start, then abort after 2.5 s -> IDLE next cycle, LD=0, seg=0, endOfShow stays 0. Simultaneous start+abort from IDLE -> stays IDLE.
4. Restart. Start psw=7'h0F, after 3 s start psw=7'h70 -> LD=7'h70, display back to 5, endOfShow rises only 5 full seconds after the second start. A start in DONE clears endOfShow the same edge.
5. Blink mode. BLINK=1, TICKS_PER_SEC=8, psw=7'h7F -> LD=7F for 4 cycles, 0 for 4 cycles, repeated for SECONDS periods.
6. Async reset mid-show. rst_n low between clock edges at 2 s -> all outputs at reset values without waiting for a clk edge. After release, no activity until a new start.
